// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and prescaler sizing for the interval timer
package timer_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ARMED = 2'b01, S_COUNT = 2'b10} state_t;
  function automatic int psc_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction
endpackage

// File: rtl/down_counter_n.sv
// down_counter_n: loadable W-bit down counter from cascaded base-2 cells
module down_counter_n #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ei,
  output logic [W-1:0] q,
  output logic         eu
);
  logic [W:0] b;
  assign b[0] = ei;
  for (genvar i = 0; i < W; i++) begin : g_cell
    assign b[i+1] = b[i] & ~q[i];
    always_ff @(posedge clock)
      q[i] <= reset ? 1'b0 : load ? d[i] : q[i] ^ b[i];
  end
  assign eu = b[W];
endmodule

// File: rtl/down_timer_ctrl.sv
// down_timer_ctrl: soc/eoc sequencer driving a prescaled down counter
module down_timer_ctrl
  import timer_pkg::*;
#(
  parameter int W        = 8,
  parameter int PRESCALE = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         soc,
  input  logic [W-1:0] n,
  input  logic         abort,
  output logic         eoc,
  output logic [W-1:0] q,
  output logic         tick
);
  localparam int PW = psc_width(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  state_t state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic idle, cnt, zero, load, eu;
  // the unused 2'b11 encoding behaves as IDLE
  assign idle = state_q != S_ARMED && state_q != S_COUNT;
  assign cnt  = state_q == S_COUNT;
  assign zero = q == '0;
  assign eoc  = idle;
  assign tick = cnt && !zero && psc_q == PMAX;
  assign load = idle ? soc && !abort : abort;
  always_comb begin
    state_d = state_q == S_ARMED ? (abort ? S_IDLE : soc ? S_ARMED : S_COUNT)
            : cnt ? (abort || zero ? S_IDLE : S_COUNT)
            : (soc && !abort ? S_ARMED : S_IDLE);
    psc_d = cnt && !abort && !zero && !tick ? psc_q + 1'b1 : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      psc_q   <= '0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      assert (!eu);
    end
  end
  down_counter_n #(.W(W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .load (load),
    .d    (idle ? n : '0),
    .ei   (tick),
    .q    (q),
    .eu   (eu)
  );
endmodule

// File: tb/tb_down_timer_ctrl.sv
// tb_down_timer_ctrl: directed stimulus with a queued-expectation scoreboard
module tb_down_timer_ctrl;
  localparam int W = 8;
  localparam int P = 4;
  logic clk = 1'b0;
  logic reset, soc, abort;
  logic [W-1:0] n;
  logic eoc, tick;
  logic [W-1:0] q;
  typedef struct {
    string        tag;
    logic         eoc;
    logic [W-1:0] q;
    logic         tick;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  down_timer_ctrl #(.W(W), .PRESCALE(P)) dut (
    .clock(clk), .reset(reset), .soc(soc), .n(n), .abort(abort),
    .eoc(eoc), .q(q), .tick(tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (eoc !== e.eoc || q !== e.q || tick !== e.tick) begin
        miscompares++;
        $display("FAIL %s: got eoc=%b q=%0d tick=%b, want eoc=%b q=%0d tick=%b",
                 e.tag, eoc, q, tick, e.eoc, e.q, e.tick);
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic [W-1:0] nv, input logic a,
                     input string tag, input logic ee, input logic [W-1:0] eq, input logic et);
    exp_t e;
    reset = r; soc = s; n = nv; abort = a;
    @(posedge clk);
    e.tag = tag; e.eoc = ee; e.q = eq; e.tick = et;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // stop_k: after observing COUNT cycle stop_k, apply abort (use_rst=0) or reset
  task automatic run_count(input int nv, input int hold, input int stop_k, input logic use_rst,
                           input string tag);
    int last;
    last = nv * P + 1;
    cyc(0, 1, W'(nv), 0, {tag, "_start"}, 0, W'(nv), 0);
    for (int h = 1; h < hold; h++) cyc(0, 1, W'(nv), 0, {tag, "_armed"}, 0, W'(nv), 0);
    for (int k = 1; k <= last; k++) begin
      if (stop_k != 0 && k == stop_k + 1) begin
        cyc(use_rst, 0, 8'hAA, !use_rst, {tag, "_stop"}, 1, 0, 0);
        return;
      end
      cyc(0, 0, 8'hAA, 0, {tag, "_count"}, 0, W'(nv - (k - 1) / P),
          (k % P == 0) && (k <= nv * P));
    end
    cyc(0, 0, 8'hAA, 0, {tag, "_done"}, 1, 0, 0);
  endtask

  initial begin
    reset = 1; soc = 1; n = 5; abort = 0;
    cyc(1, 1, 5, 0, "reset0", 1, 0, 0);
    cyc(1, 1, 5, 0, "reset1", 1, 0, 0);
    cyc(0, 0, 5, 0, "post_reset0", 1, 0, 0);
    cyc(0, 0, 5, 0, "post_reset1", 1, 0, 0);
    run_count(3, 1, 0, 0, "n3");
    run_count(0, 1, 0, 0, "n0");
    run_count(3, 5, 0, 0, "n3_hold");
    run_count(6, 1, 17, 0, "n6_abort");
    cyc(0, 1, 9, 1, "soc_abort_idle", 1, 0, 0);
    cyc(0, 0, 9, 0, "idle_after_abort", 1, 0, 0);
    run_count(1, 1, 0, 0, "n1");
    run_count(255, 1, 0, 0, "n255");
    run_count(255, 1, 621, 1, "n255_reset");
    cyc(0, 1, 2, 1, "armed_abort_setup", 1, 0, 0);
    cyc(0, 1, 2, 0, "armed_enter", 0, 2, 0);
    cyc(0, 0, 2, 1, "armed_abort", 1, 0, 0);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/down_timer_ctrl.md
Name: down_timer_ctrl

Overview:
Sequencer for a W-bit loadable down counter, built as a cascade of base-2 down-counter cells, used as a programmable interval timer. A consumer starts a count with the soc/eoc handshake. The block loads the period, decrements once every PRESCALE clocks, and raises eoc when the count reaches zero. It sits between a control FSM that needs timed delays and the down-counter datapath.

Parameters:
W, 8, width of period input and count register (W >= 1)
PRESCALE, 4, clocks per decrement (PRESCALE >= 1; PRESCALE = 1 means decrement every clock)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset; sampled on clock rising edge
soc    in  1  start of count, level-sensitive handshake request
n      in  W  period, sampled only in IDLE when soc=1
abort  in  1  cancel current count
eoc    out 1  end of count; 1 = idle/done, 0 = busy
q      out W  current count value (registered)
tick   out 1  one-cycle pulse on each decrement

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is named clock and the reset port reset; there is no trailing underscore because the reset is active-high.
- Reset has priority over all inputs. After reset: state=IDLE, q=0, prescaler=0, eoc=1, tick=0.
- States: IDLE, ARMED, COUNT. eoc=1 only in IDLE (Moore output).
- IDLE:
  - abort=1 keeps the block in IDLE. Abort has priority over soc, so soc=1 with abort=1 starts nothing.
  - Otherwise soc=1 makes the next state ARMED, with q<=n and prescaler<=0.
- ARMED:
  - Waits for soc=0 (handshake release). q is held and no ticks occur.
  - soc=0 makes the next state COUNT.
  - abort=1 makes the next state IDLE with q<=0.
- COUNT:
  - abort=1 makes the next state IDLE with q<=0, prescaler<=0.
  - If q==0, the next state is IDLE.
  - Otherwise, if prescaler==PRESCALE-1: q<=q-1, prescaler<=0, tick=1 in that cycle.
  - Otherwise prescaler<=prescaler+1.
  - soc is ignored during COUNT.
- tick is a combinational decode of registers only: state==COUNT & q!=0 & prescaler==PRESCALE-1. It has no input dependence.
- Latency: COUNT lasts exactly n*PRESCALE+1 cycles, and eoc rises on the edge that ends the last COUNT cycle.
- The handshake start-to-busy delay is 1 cycle: eoc falls on the edge after soc is sampled high in IDLE.
- n=0 means COUNT lasts 1 cycle, with no tick.
- q never wraps. No decrement is issued at q==0, and the borrow out of the counter chain is never produced in normal operation.
- The prescaler is ceil(log2(PRESCALE)) bits wide, minimum 1 bit, and is held at 0 outside COUNT.
- A new soc is accepted only after eoc has returned to 1. soc held high across completion starts a new count on the next cycle with the current n.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding: S_IDLE=2'b00, S_ARMED=2'b01, S_COUNT=2'b10 (2'b11 is illegal and maps to IDLE)
  - a helper constant function for the prescaler width
- One sub-module, down_counter_n:
  - W-bit loadable down counter built from cascaded base-2 cells
  - ports: clock, reset, load, d[W], ei (decrement enable), q[W], eu (borrow out)
  - the controller drives load and ei = tick.

Test Plan:
1. Reset: reset=1 for 2 cycles with soc=1, n=5 -> eoc=1, q=0, tick=0 throughout; no start after release until soc is sampled in IDLE.
2. W=8, PRESCALE=4, n=3, soc high 1 cycle -> eoc=0 next edge, q=3. COUNT entered next cycle. Ticks occur on COUNT cycles 4, 8, 12, with q going 2, 1, 0. eoc=1 after 13 COUNT cycles.
3. n=0 -> eoc=0 for ARMED plus 1 COUNT cycle, then eoc=1; tick never asserted.
4. n=3, soc held high 5 cycles -> q stays 3, no tick while ARMED. Counting starts the cycle after soc is sampled 0; total COUNT duration is still 13.
5. n=6: abort=1 when q=2 -> next edge eoc=1, q=0, tick=0. soc+abort together in IDLE -> stays IDLE. A later soc with n=1 completes in 5 COUNT cycles.
6. n=255 -> 255 ticks and eoc after 1021 COUNT cycles, q never wraps past 0. Repeat with reset=1 asserted mid-COUNT (q=100) -> next edge IDLE, q=0, eoc=1.
